// File: rtl/ddr_local_pkg.sv
// Shared types and defaults for the DDR local-interface responder.
package ddr_local_pkg;

    localparam int unsigned DEF_DATA_WIDTH  = 32;
    localparam int unsigned DEF_ADDR_WIDTH  = 25;
    localparam int unsigned DEF_MEM_AW      = 10;
    localparam int unsigned DEF_INIT_CYCLES = 64;
    localparam int unsigned DEF_RD_LATENCY  = 4;

    localparam int unsigned SIZE_W = 3;
    localparam int unsigned LEN_W  = SIZE_W + 1;

    // x^8+x^6+x^5+x^4+1 as a Fibonacci tap mask over bits [7:0]
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_WRITE,
        ST_READ_LAT,
        ST_READ
    } state_e;

    // A size of zero still moves one word.
    function automatic logic [LEN_W-1:0] burst_len(input logic [SIZE_W-1:0] size);
        return (size == '0) ? LEN_W'(1) : {1'b0, size};
    endfunction

endpackage

// File: rtl/ddr_local_responder_if.sv
// Local-bus request/data signals between a master and the responder.
interface ddr_local_responder_if #(
    parameter int unsigned DATA_WIDTH = ddr_local_pkg::DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = ddr_local_pkg::DEF_ADDR_WIDTH
);
    logic [ADDR_WIDTH-1:0]             local_address;
    logic [ddr_local_pkg::SIZE_W-1:0]  local_size;
    logic                              local_burstbegin;
    logic                              local_read_req;
    logic                              local_write_req;
    logic [DATA_WIDTH-1:0]             local_wdata;
    logic                              local_ready;
    logic                              local_wdata_req;
    logic [DATA_WIDTH-1:0]             local_rdata;
    logic                              local_rdata_valid;
    logic                              local_init_done;

    modport master (
        output local_address, local_size, local_burstbegin, local_read_req,
               local_write_req, local_wdata,
        input  local_ready, local_wdata_req, local_rdata, local_rdata_valid,
               local_init_done
    );

    modport slave (
        input  local_address, local_size, local_burstbegin, local_read_req,
               local_write_req, local_wdata,
        output local_ready, local_wdata_req, local_rdata, local_rdata_valid,
               local_init_done
    );
endinterface

// File: rtl/ddr_resp_ram.sv
// Single-port synchronous word store with a registered read port.
module ddr_resp_ram #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned AW         = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we_i,
    input  logic                  re_i,
    input  logic [AW-1:0]         addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);
    logic [DATA_WIDTH-1:0] mem_q [0:(2**AW)-1];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/ddr_local_responder.sv
// DDR controller local-interface stand-in serving bursts from an on-chip store.
// Optional DDR_RESP_STALL_EN: pseudo-random LFSR gating of local_ready in IDLE.
module ddr_local_responder
    import ddr_local_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int unsigned MEM_AW      = DEF_MEM_AW,
    parameter int unsigned INIT_CYCLES = DEF_INIT_CYCLES,
    parameter int unsigned RD_LATENCY  = DEF_RD_LATENCY
) (
    input  logic                  clk,
    input  logic                  reset,
    ddr_local_responder_if.slave  bus
);
    localparam int unsigned INIT_W = $clog2(INIT_CYCLES + 1);
    localparam int unsigned LAT_W  = $clog2(RD_LATENCY + 1);
    localparam int unsigned CNT_W  = (LAT_W > 4) ? LAT_W : 4;

    state_e                 state_q, state_d;
    logic [INIT_W-1:0]      init_cnt_q, init_cnt_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic [MEM_AW-1:0]      base_q, base_d;
    logic                   init_done_q, init_done_d;
    logic                   wdata_req_q, wdata_req_d;
    logic                   rvalid_q, rvalid_d;

    logic                   ram_we_c;
    logic                   ram_re_c;
    logic [MEM_AW-1:0]      ram_addr_c;
    logic [DATA_WIDTH-1:0]  ram_rdata;
    logic                   stall_ok_c;
    logic                   ready_c;
    logic                   accept_c;
    logic                   unused_addr_c;

`ifdef DDR_RESP_STALL_EN
    logic [7:0] lfsr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    assign stall_ok_c = lfsr_q[0];
`else
    assign stall_ok_c = 1'b1;
`endif

    assign ready_c       = (state_q == ST_IDLE) && init_done_q && stall_ok_c;
    assign accept_c      = ready_c && bus.local_burstbegin &&
                           (bus.local_read_req || bus.local_write_req);
    assign unused_addr_c = ^bus.local_address[ADDR_WIDTH-1:MEM_AW];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            base_q      <= '0;
            init_done_q <= 1'b0;
            wdata_req_q <= 1'b0;
            rvalid_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            base_q      <= base_d;
            init_done_q <= init_done_d;
            wdata_req_q <= wdata_req_d;
            rvalid_q    <= rvalid_d;
        end
    end

    // Write beat k is captured while cnt_q == k+1; read word k is fetched while cnt_q == k.
    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        base_d      = base_q;
        init_done_d = init_done_q;
        wdata_req_d = 1'b0;
        rvalid_d    = 1'b0;
        ram_we_c    = 1'b0;
        ram_re_c    = 1'b0;
        ram_addr_c  = base_q + MEM_AW'(cnt_q);

        case (state_q)
            ST_INIT: begin
                if (init_cnt_q == INIT_W'(INIT_CYCLES - 1)) begin
                    state_d     = ST_IDLE;
                    init_done_d = 1'b1;
                end else begin
                    init_cnt_d = init_cnt_q + INIT_W'(1);
                end
            end

            ST_IDLE: begin
                if (accept_c) begin
                    base_d = bus.local_address[MEM_AW-1:0];
                    len_d  = burst_len(bus.local_size);
                    cnt_d  = '0;
                    if (bus.local_write_req) begin
                        state_d     = ST_WRITE;
                        wdata_req_d = 1'b1;
                    end else if (RD_LATENCY == 1) begin
                        state_d = ST_READ;
                    end else begin
                        state_d = ST_READ_LAT;
                    end
                end
            end

            ST_WRITE: begin
                wdata_req_d = (cnt_q + CNT_W'(1)) < CNT_W'(len_q);
                if (cnt_q != '0) begin
                    ram_we_c   = 1'b1;
                    ram_addr_c = base_q + MEM_AW'(cnt_q - CNT_W'(1));
                end
                if (cnt_q == CNT_W'(len_q)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_READ_LAT: begin
                // RAM read register supplies the final cycle of latency.
                if (cnt_q == CNT_W'(RD_LATENCY - 2)) begin
                    state_d = ST_READ;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_READ: begin
                if (cnt_q < CNT_W'(len_q)) begin
                    ram_re_c = 1'b1;
                    rvalid_d = 1'b1;
                    cnt_d    = cnt_q + CNT_W'(1);
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end

            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    ddr_resp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .AW         (MEM_AW)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .we_i    (ram_we_c),
        .re_i    (ram_re_c),
        .addr_i  (ram_addr_c),
        .wdata_i (bus.local_wdata),
        .rdata_o (ram_rdata)
    );

    assign bus.local_ready       = ready_c;
    assign bus.local_wdata_req   = wdata_req_q;
    assign bus.local_rdata       = ram_rdata;
    assign bus.local_rdata_valid = rvalid_q;
    assign bus.local_init_done   = init_done_q;
endmodule

// File: tb/tb_ddr_local_responder.sv
// Self-checking bench for ddr_local_responder: vector table, corner sequences, random traffic.
module tb_ddr_local_responder;

    localparam int DW    = 32;
    localparam int AW    = 25;
    localparam int MAW   = 10;
    localparam int DEPTH = 1 << MAW;
    localparam int INITC = 64;
    localparam int L     = 4;
    localparam int NV    = 9;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    ddr_local_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    ddr_local_responder #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .MEM_AW      (MAW),
        .INIT_CYCLES (INITC),
        .RD_LATENCY  (L)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mdl   [DEPTH];
    bit          known [DEPTH];

    typedef struct {
        bit          wr;
        bit          both;
        int          addr;
        int          size;
        logic [31:0] d0;
        int          beats;
        logic [31:0] first;
    } vec_t;

    vec_t vecs [NV];

`ifdef DDR_RESP_STALL_EN
    bit [7:0] tb_lfsr;
    always @(posedge clk or posedge reset) begin
        if (reset) tb_lfsr <= 8'hA5;
        else       tb_lfsr <= {tb_lfsr[6:0], tb_lfsr[7] ^ tb_lfsr[5] ^ tb_lfsr[4] ^ tb_lfsr[3]};
    end
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_bus();
        bus.local_burstbegin = 1'b0;
        bus.local_read_req   = 1'b0;
        bus.local_write_req  = 1'b0;
    endtask

    // Hold a request until the responder shows ready; returns just after the accept edge.
    task automatic request(input bit wr, input bit rd, input int addr, input int size, output bit ok);
        logic r;
        ok = 1'b0;
        @(negedge clk);
        bus.local_address    = AW'(addr);
        bus.local_size       = 3'(size);
        bus.local_burstbegin = 1'b1;
        bus.local_write_req  = wr;
        bus.local_read_req   = rd;
        for (int i = 0; i < 300; i++) begin
            r = bus.local_ready;
`ifdef DDR_RESP_STALL_EN
            if (r === 1'b1) check("stall_gate", 64'(tb_lfsr[0]), 64'(1));
`endif
            @(posedge clk);
            if (r === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        #1;
        idle_bus();
        if (!ok) check("accept_timeout", 64'(0), 64'(1));
    endtask

    task automatic do_write(input bit both, input int addr, input int size, input logic [31:0] d0,
                            output int beats);
        int len   = (size == 0) ? 1 : size;
        int first = -1;
        int last  = -1;
        int k     = 0;
        bit prev  = 1'b0;
        bit saw_rv = 1'b0;
        bit ok;
        beats = 0;
        request(1'b1, both, addr, size, ok);
        if (!ok) return;
        for (int s = 0; s < len + 3; s++) begin
            @(negedge clk);
            if (prev) begin
                bus.local_wdata = d0 + 32'(k);
                k++;
            end else begin
                bus.local_wdata = $urandom;
            end
            prev = bus.local_wdata_req;
            if (prev) begin
                beats++;
                if (first < 0) first = s;
                last = s;
            end
            if (bus.local_rdata_valid === 1'b1) saw_rv = 1'b1;
`ifndef DDR_RESP_STALL_EN
            if (s == len)     check("wr_ready_busy", 64'(bus.local_ready), 64'(0));
            if (s == len + 1) check("wr_ready_back", 64'(bus.local_ready), 64'(1));
`endif
        end
        check("wr_first_beat", 64'(first), 64'(0));
        check("wr_last_beat", 64'(last), 64'(len - 1));
        check("wr_no_rvalid", 64'(saw_rv), 64'(0));
        for (int j = 0; j < len; j++) begin
            mdl[(addr + j) % DEPTH]   = d0 + 32'(j);
            known[(addr + j) % DEPTH] = 1'b1;
        end
    endtask

    task automatic do_read(input int addr, input int size, output int beats, output logic [31:0] first_data);
        int len    = (size == 0) ? 1 : size;
        int first  = -1;
        bit saw_wr = 1'b0;
        bit ok;
        beats      = 0;
        first_data = 'x;
        request(1'b0, 1'b1, addr, size, ok);
        if (!ok) return;
        for (int s = 0; s < L + len + 2; s++) begin
            @(negedge clk);
            if (bus.local_rdata_valid === 1'b1) begin
                int b = s - L;
                beats++;
                if (first < 0) begin
                    first      = s;
                    first_data = bus.local_rdata;
                end
                if (b >= 0 && b < len && known[(addr + b) % DEPTH])
                    check("rd_data", 64'(bus.local_rdata), 64'(mdl[(addr + b) % DEPTH]));
            end
            if (bus.local_wdata_req === 1'b1) saw_wr = 1'b1;
`ifndef DDR_RESP_STALL_EN
            if (s == L + len - 1) check("rd_ready_busy", 64'(bus.local_ready), 64'(0));
            if (s == L + len)     check("rd_ready_back", 64'(bus.local_ready), 64'(1));
`endif
        end
        check("rd_first_valid", 64'(first), 64'(L));
        check("rd_no_wreq", 64'(saw_wr), 64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          beats;
        logic [31:0] fd;
        bit          ok;
        bit          saw;
        bit          early;
        bit          got;

        for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;

        vecs[0] = '{1'b1, 1'b0, 'h10,        4, 32'hA0, 4, 32'h0};
        vecs[1] = '{1'b0, 1'b0, 'h10,        4, 32'h0,  4, 32'hA0};
        vecs[2] = '{1'b1, 1'b0, DEPTH - 2,   4, 32'h1,  4, 32'h0};
        vecs[3] = '{1'b0, 1'b0, 0,           2, 32'h0,  2, 32'h3};
        vecs[4] = '{1'b0, 1'b0, DEPTH - 1,   2, 32'h0,  2, 32'h2};
        vecs[5] = '{1'b1, 1'b1, 'h20,        3, 32'hC0, 3, 32'h0};
        vecs[6] = '{1'b0, 1'b0, 'h20,        3, 32'h0,  3, 32'hC0};
        vecs[7] = '{1'b1, 1'b0, DEPTH + 'h30, 0, 32'h55, 1, 32'h0};
        vecs[8] = '{1'b0, 1'b0, 'h30,        0, 32'h0,  1, 32'h55};

        reset = 1'b1;
        idle_bus();
        bus.local_address = '0;
        bus.local_size    = '0;
        bus.local_wdata   = '0;
        repeat (3) @(negedge clk);
        check("rst_init_done", 64'(bus.local_init_done), 64'(0));
        check("rst_ready", 64'(bus.local_ready), 64'(0));
        check("rst_wdata_req", 64'(bus.local_wdata_req), 64'(0));
        check("rst_rvalid", 64'(bus.local_rdata_valid), 64'(0));
        check("rst_rdata", 64'(bus.local_rdata), 64'(0));
        reset = 1'b0;

        // Init window: done rises after exactly INITC edges; requests are ignored meanwhile.
        saw   = 1'b0;
        early = 1'b0;
        for (int c = 1; c <= 70; c++) begin
            @(negedge clk);
            if (c == 10) begin
                bus.local_address    = AW'('h10);
                bus.local_size       = 3'd2;
                bus.local_burstbegin = 1'b1;
                bus.local_write_req  = 1'b1;
            end
            if (c == 11) idle_bus();
            if (bus.local_wdata_req === 1'b1) saw = 1'b1;
            if (c < INITC && bus.local_init_done !== 1'b0) early = 1'b1;
            if (c == INITC - 1) begin
                check("init_done_63", 64'(bus.local_init_done), 64'(0));
                check("init_ready_63", 64'(bus.local_ready), 64'(0));
            end
            if (c == INITC) begin
                check("init_done_64", 64'(bus.local_init_done), 64'(1));
`ifndef DDR_RESP_STALL_EN
                check("init_ready_64", 64'(bus.local_ready), 64'(1));
`endif
            end
        end
        check("init_done_early", 64'(early), 64'(0));
        check("init_req_ignored", 64'(saw), 64'(0));
        check("init_done_sticky", 64'(bus.local_init_done), 64'(1));

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].wr) begin
                do_write(vecs[i].both, vecs[i].addr, vecs[i].size, vecs[i].d0, beats);
                check($sformatf("vec%0d_wbeats", i), 64'(beats), 64'(vecs[i].beats));
            end else begin
                do_read(vecs[i].addr, vecs[i].size, beats, fd);
                check($sformatf("vec%0d_rbeats", i), 64'(beats), 64'(vecs[i].beats));
                check($sformatf("vec%0d_first", i), 64'(fd), 64'(vecs[i].first));
            end
        end

        // Reset during a read burst, right after its first beat.
        request(1'b0, 1'b1, 'h10, 4, ok);
        for (int s = 0; s <= L; s++) @(negedge clk);
        check("midrd_valid_before", 64'(bus.local_rdata_valid), 64'(1));
        check("midrd_data_before", 64'(bus.local_rdata), 64'(mdl['h10]));
        reset = 1'b1;
        #1;
        check("midrd_valid_rst", 64'(bus.local_rdata_valid), 64'(0));
        check("midrd_done_rst", 64'(bus.local_init_done), 64'(0));
        check("midrd_ready_rst", 64'(bus.local_ready), 64'(0));
        check("midrd_rdata_rst", 64'(bus.local_rdata), 64'(0));
        repeat (2) @(negedge clk);
        reset = 1'b0;
        got = 1'b0;
        saw = 1'b0;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk);
            if (bus.local_rdata_valid === 1'b1) saw = 1'b1;
            if (bus.local_init_done === 1'b1) got = 1'b1;
        end
        check("midrd_reinit", 64'(got), 64'(1));
        check("midrd_no_late_beats", 64'(saw), 64'(0));
        do_read('h10, 4, beats, fd);
        check("midrd_reread_beats", 64'(beats), 64'(4));
        check("midrd_reread_first", 64'(fd), 64'(32'hA0));

        // Random traffic near the bottom and the wrap point, with high address bits set.
        for (int t = 0; t < 60; t++) begin
            int  addr = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 40))
                                                    : int'($urandom_range(DEPTH - 8, DEPTH - 1));
            int  size = int'($urandom_range(0, 7));
            int  len  = (size == 0) ? 1 : size;
            addr = addr + DEPTH * int'($urandom_range(0, 2));
            if ($urandom_range(0, 1) == 1) begin
                do_write($urandom_range(0, 3) == 0, addr, size, $urandom, beats);
                check("rnd_wbeats", 64'(beats), 64'(len));
            end else begin
                do_read(addr, size, beats, fd);
                check("rnd_rbeats", 64'(beats), 64'(len));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
